// File: rtl/pr_avmm_freeze_bridge.sv
// Registered AVMM command stage between a PR region and the NoC port.
// Drains and isolates the region on freeze_req; recovers hung reads by timeout.
module pr_avmm_freeze_bridge #(
    parameter int ADDR_W          = 20,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_W           = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [ADDR_W-1:0] s_address,
    input  logic [DATA_W-1:0] s_writedata,
    output logic              s_waitrequest,
    output logic [DATA_W-1:0] s_readdata,
    output logic              s_readdatavalid,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    input  logic              freeze_req,
    output logic              freeze_ack,
    input  logic              err_clr,
    output logic [1:0]        err_status,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [OW:0]   MAX_V    = (OW+1)'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, FROZEN} state_t;

    state_t            state_q, state_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              is_read_q, is_read_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              ack_q, ack_d;
    logic [1:0]        err_q, err_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic        pend_rd;
    logic [OW:0] rd_sum;
    logic        rd_full;
    logic        stall;
    logic        load;
    logic        issue_rd;
    logic        fwd;
    logic        spur;
    logic        timeout;

    always_comb begin
        // A pending read counts as in flight so the limit holds even
        // when it issues in the same cycle a new read is accepted.
        pend_rd  = cmd_valid_q & is_read_q;
        rd_sum   = {1'b0, outst_q} + {{OW{1'b0}}, pend_rd};
        rd_full  = rd_sum >= MAX_V;
        stall    = (state_q != RUN) | (cmd_valid_q & m_waitrequest)
                 | (s_read & rd_full);
        load     = (s_read | s_write) & ~stall;
        issue_rd = m_read & ~m_waitrequest;
        fwd      = m_readdatavalid & (outst_q != '0);
        spur     = m_readdatavalid & (outst_q == '0);
        timeout  = (state_q == DRAIN) & (outst_q != '0)
                 & ~m_readdatavalid & (tmo_q == TMO_LAST);

        cmd_valid_d = cmd_valid_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        data_d      = data_q;
        if (load) begin
            cmd_valid_d = 1'b1;
            is_read_d   = s_read;
            addr_d      = s_address;
            data_d      = s_writedata;
        end else if (!m_waitrequest || timeout) begin
            cmd_valid_d = 1'b0;
        end

        outst_d = outst_q;
        if (timeout) begin
            outst_d = '0;
        end else if (issue_rd && !fwd) begin
            outst_d = outst_q + OW'(1);
        end else if (!issue_rd && fwd) begin
            outst_d = outst_q - OW'(1);
        end

        tmo_d = '0;
        if (state_q == DRAIN && outst_q != '0 && !m_readdatavalid && !timeout) begin
            tmo_d = tmo_q + TW'(1);
        end

        rvalid_d = fwd & (state_q != FROZEN);
        rdata_d  = fwd ? m_readdata : rdata_q;

        state_d = state_q;
        unique case (state_q)
            RUN:     if (freeze_req) state_d = DRAIN;
            DRAIN:   if (!cmd_valid_d && outst_d == '0) state_d = FROZEN;
            FROZEN:  if (!freeze_req) state_d = RUN;
            default: state_d = RUN;
        endcase

        ack_d = (state_q == FROZEN) & freeze_req;

        err_d = err_q | {spur, timeout};
        if (err_clr) err_d = '0;

        drop_d = drop_q;
        if (state_q == FROZEN && (s_read || s_write) && drop_q != '1) begin
            drop_d = drop_q + CNT_W'(1);
        end
        if (err_clr) drop_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            cmd_valid_q <= 1'b0;
            is_read_q   <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            outst_q     <= '0;
            tmo_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            outst_q     <= outst_d;
            tmo_q       <= tmo_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
        end
    end

    assign s_waitrequest   = rst | stall;
    assign s_readdata      = rdata_q;
    assign s_readdatavalid = rvalid_q;
    assign m_read          = cmd_valid_q & is_read_q & (state_q != FROZEN);
    assign m_write         = cmd_valid_q & ~is_read_q & (state_q != FROZEN);
    assign m_address       = addr_q;
    assign m_writedata     = data_q;
    assign freeze_ack      = ack_q;
    assign err_status      = err_q;
    assign drop_cnt        = drop_q;

endmodule
